// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory-stage load/store unit: bus size codes,
// byte-strobe patterns, the FSM state type, the registered request payload and
// small helpers for size normalisation and alignment checking.
// -----------------------------------------------------------------------------
package mem_pkg;

    // Bus / instruction size codes (code 3 is reserved and behaves as a word)
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Byte-strobe patterns
    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_LO   = 4'b0011;
    localparam logic [3:0] WSTRB_HI   = 4'b1100;
    localparam logic [3:0] WSTRB_ALL  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN_REQ,
        ST_DRAIN_DATA
    } state_e;

    // Everything the bus sees for one transaction, plus what the load
    // extractor needs once the data returns.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SZ_WORD : size;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (norm_size(size))
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// SRAM-like data bus between the load/store unit (master) and memory (slave).
//   data_req/data_wr/data_size/data_addr/data_wdata/data_wstrb : request side
//   data_addr_ok : address accepted      data_data_ok : data phase complete
//   data_rdata   : read data, valid with data_data_ok
// -----------------------------------------------------------------------------
interface mem_access_unit_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational lane select and sign/zero extension of bus read data.
//   addr_lo : byte offset of the access     size : SZ_* code
//   uns     : zero-extend when set          rdata : raw 32-bit bus word
//   result  : aligned, extended load value
// -----------------------------------------------------------------------------
module load_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] rdata,
    output logic [31:0] result
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first), otherwise synthesis infers a latch.
        byte_lane = rdata[7:0];
        case (addr_lo)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (norm_size(size))
            SZ_BYTE: result = {{24{~uns & byte_lane[7]}}, byte_lane};
            SZ_HALF: result = {{16{~uns & half_lane[15]}}, half_lane};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage load/store unit. Turns each aligned load/store in M into one
// bus transaction, flags misaligned accesses instead of issuing them, stalls
// the pipeline while a transaction is outstanding and drains transactions
// whose instruction was flushed so the bus protocol is never broken.
//   clk, rst (async, active-low)
//   mem_en_M/mem_wr_M/mem_size_M/mem_unsigned_M/addr_M/wdata_M : M-stage access
//   flush_M : kill the instruction in M   hold_M : M/W stalled elsewhere
//   stall_mem : to hazard unit            rdata_M : aligned load result
//   adel/ades/badvaddr : misaligned load/store and the faulting address
//   bus : data bus master port
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en_M,
    input  logic        mem_wr_M,
    input  logic [1:0]  mem_size_M,
    input  logic        mem_unsigned_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    input  logic        flush_M,
    input  logic        hold_M,
    output logic        stall_mem,
    output logic [31:0] rdata_M,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr,
    mem_access_unit_if.master bus
);
    state_e      state, state_nxt;
    req_t        req_q, req_new, req_out;
    logic [31:0] cap_q, load_res;
    logic [1:0]  size_n;
    logic        mis, issue;

    assign size_n = norm_size(mem_size_M);
    assign mis    = mem_en_M & misaligned(mem_size_M, addr_M[1:0]);

    // NOTE: rst gates the issue term directly so that an access held in M
    // while reset is low cannot raise data_req through the combinational path.
    assign issue = rst & (state == ST_IDLE) & mem_en_M & ~mis & ~flush_M;

    assign adel     = rst & mis & ~mem_wr_M;
    assign ades     = rst & mis & mem_wr_M;
    assign badvaddr = (adel | ades) ? addr_M : 32'h0;

    // Payload as it would be issued from the current M-stage inputs
    always_comb begin
        req_new       = '0;
        req_new.wr    = mem_wr_M;
        req_new.size  = size_n;
        req_new.uns   = mem_unsigned_M;
        req_new.addr  = addr_M;
        case (size_n)
            SZ_BYTE: begin
                req_new.wstrb = 4'b0001 << addr_M[1:0];
                req_new.wdata = {4{wdata_M[7:0]}};
            end
            SZ_HALF: begin
                req_new.wstrb = addr_M[1] ? WSTRB_HI : WSTRB_LO;
                req_new.wdata = {2{wdata_M[15:0]}};
            end
            default: begin
                req_new.wstrb = WSTRB_ALL;
                req_new.wdata = wdata_M;
            end
        endcase
        if (!mem_wr_M) req_new.wstrb = WSTRB_NONE;
    end

    // Extraction uses the registered payload: M may already hold a different
    // instruction by the time the data returns.
    load_align u_load_align (
        .addr_lo (req_q.addr[1:0]),
        .size    (req_q.size),
        .uns     (req_q.uns),
        .rdata   (bus.data_rdata),
        .result  (load_res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            req_q <= '0;
            cap_q <= '0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every register samples pre-edge values regardless of order.
            state <= state_nxt;
            if (issue) req_q <= req_new;
            if (state == ST_WAIT && bus.data_data_ok && !flush_M && !req_q.wr)
                cap_q <= load_res;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.data_req = 1'b0;
        stall_mem    = 1'b0;
        req_out      = req_q;
        case (state)
            ST_IDLE: begin
                if (issue) begin
                    req_out      = req_new;
                    bus.data_req = 1'b1;
                    stall_mem    = 1'b1;
                    state_nxt    = bus.data_addr_ok ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                bus.data_req = 1'b1;
                stall_mem    = 1'b1;
                // data_ok cannot precede acceptance, so only addr_ok counts here
                if (bus.data_addr_ok) state_nxt = flush_M ? ST_DRAIN_DATA : ST_WAIT;
                else if (flush_M)     state_nxt = ST_DRAIN_REQ;
            end
            ST_WAIT: begin
                stall_mem = 1'b1;
                if (bus.data_data_ok) state_nxt = flush_M ? ST_IDLE : ST_DONE;
                else if (flush_M)     state_nxt = ST_DRAIN_DATA;
            end
            ST_DONE: begin
                if (flush_M || !hold_M) state_nxt = ST_IDLE;
            end
            ST_DRAIN_REQ: begin
                bus.data_req = 1'b1;
                stall_mem    = mem_en_M;
                if (bus.data_addr_ok) state_nxt = ST_DRAIN_DATA;
            end
            ST_DRAIN_DATA: begin
                stall_mem = mem_en_M;
                if (bus.data_data_ok) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.data_wr    = req_out.wr;
    assign bus.data_size  = req_out.size;
    assign bus.data_addr  = req_out.addr;
    assign bus.data_wdata = req_out.wdata;
    assign bus.data_wstrb = req_out.wstrb;
    assign rdata_M        = cap_q;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit between the M pipeline register and the SRAM-like data bus. Each load/store presented in M becomes exactly one bus transaction with byte strobes and a size code. Load data is aligned and sign- or zero-extended, and misaligned accesses are flagged instead of issued. The unit drives a stall into the hazard unit while a transaction is outstanding. It drains cancelled transactions safely when M is flushed.

## Interface
Parameters:
- none; all widths are fixed at 32-bit address and data.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_en_M`  in  1  the instruction in M is a load or store.
- `mem_wr_M`  in  1  1 = store, 0 = load.
- `mem_size_M`  in  2  0 = byte, 1 = half, 2 = word (3 is reserved and treated as word).
- `mem_unsigned_M`  in  1  zero-extend loads (LBU/LHU).
- `addr_M`  in  32  byte address (ALU output).
- `wdata_M`  in  32  store data, right-aligned.
- `flush_M`  in  1  kill the instruction in M.
- `hold_M`  in  1  the M/W register is stalled by another source.
- `stall_mem`  out  1  to the hazard unit.
- `rdata_M`  out  32  aligned and extended load result.
- `adel`, `ades`  out  1 each  misaligned load / misaligned store.
- `badvaddr`  out  32  offending address.
- `data_req`  out  1  bus request.
- `data_wr`  out  1  bus write.
- `data_size`  out  2  bus size code.
- `data_addr`  out  32  bus byte address.
- `data_wdata`  out  32  bus write data.
- `data_wstrb`  out  4  bus byte strobes.
- `data_addr_ok`  in  1  bus has accepted the address.
- `data_data_ok`  in  1  bus data phase is complete.
- `data_rdata`  in  32  bus read data.

## Operation
- Misalignment:
  - half with `addr_M[0]`=1, or word with `addr_M[1:0]`≠0, raises `adel` (load) or `ades` (store) combinationally and sets `badvaddr`=`addr_M`.
  - No request is issued and `stall_mem` stays 0.
- Strobes and data:
  - byte: `wstrb` = 1<<addr[1:0], `wdata` = {4{b}}.
  - half: `wstrb` = addr[1] ? 1100 : 0011, `wdata` = {2{h}}.
  - word: `wstrb` = 1111.
  - Loads drive `wstrb`=0000.
- Load extract: byte lane `addr[1:0]`, half lane `addr[1]`; sign-extend unless `mem_unsigned_M`.
- FSM states:
  - IDLE: when `mem_en_M` & aligned & ~`flush_M`, assert `data_req` and register the payload. Go to WAIT if `data_addr_ok`, else REQ.
  - REQ: hold `data_req` and keep the payload stable until `data_addr_ok`, then go to WAIT. `flush_M` here moves to DRAIN_REQ.
  - WAIT: on `data_data_ok`, capture the extracted load data and go to DONE. `flush_M` here moves to DRAIN_DATA.
  - DONE: `rdata_M` comes from the capture register. Return to IDLE on the first cycle with ~`hold_M` (M advances). `flush_M` also returns to IDLE.
  - DRAIN_REQ: keep `data_req` asserted until `data_addr_ok`, then go to DRAIN_DATA.
  - DRAIN_DATA: discard data on `data_data_ok`, then go to IDLE.
- `stall_mem`:
  - 1 in the IDLE issue cycle, in REQ, and in WAIT.
  - 0 in DONE.
  - In DRAIN states, equals `mem_en_M` (a new access waits for the drain to finish).
- Flush never aborts a bus transaction. Discarded data never reaches `rdata_M`, and stores already accepted complete on the bus.

## Timing
- Reset (async assert, sync release):
  - state IDLE.
  - `data_req`, `data_wr`, `stall_mem`, `adel`, `ades` = 0.
  - `data_addr`, `data_wdata`, `badvaddr`, `rdata_M` = 0.
  - `data_size`, `data_wstrb` = 0.
- Reset mid-transaction returns to IDLE and drops `data_req` immediately.
- Best case: `addr_ok` in the issue cycle and `data_ok` the next cycle gives 2 stall cycles; the result is valid in DONE, cycle 2.
- Each extra wait cycle on `addr_ok` or `data_ok` adds exactly one stall cycle.
- `addr_ok` and `data_ok` in the same cycle while in REQ: only `addr_ok` is honoured, and the bus must not assert `data_ok` before acceptance.
- At most one outstanding transaction.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`.
  - FSM state enum (3-bit).
  - `wstrb` constants.
- Sub-module `load_align`: combinational lane select and extension (addr[1:0], size, unsigned, rdata → 32-bit result).
- The FSM, payload registers and capture register stay in the top level.

## Test plan
- LW at 0x100 with `addr_ok` immediate and `data_ok` next cycle, rdata 0xDEADBEEF → `rdata_M`=0xDEADBEEF in DONE, `stall_mem` high exactly 2 cycles.
- LB at 0x103 with rdata 0x80FF_0000; then LBU at 0x103 → 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x202 with wdata 0x1234ABCD → `data_wstrb`=1100, `data_wdata`=0xABCDABCD, `data_wr`=1.
- LW at 0x101 → `adel`=1, `badvaddr`=0x101, no `data_req`, `stall_mem`=0. SW at 0x102 → `ades`=1.
- `flush_M` in WAIT, with `data_ok` 3 cycles later and a new load in M → old data discarded, the new request issues only after drain, and `stall_mem` stays high through the drain.
- `addr_ok` held low for 4 cycles → `data_req` and the payload remain stable all 4 cycles. `rst` pulsed low in REQ → all outputs return to 0 immediately.
